// File: rtl/rsa_stream_ctrl.sv
// Byte-stream front end for an RSA core: loads N, E and M (96 bytes), starts the
// core, waits for completion and streams the 32-byte result back out.
module rsa_stream_ctrl #(
   parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       core_we,
   output logic       core_oe,
   output logic       core_start,
   output logic [1:0] core_reg_sel,
   output logic [4:0] core_addr,
   output logic [7:0] core_wdata,
   input  logic [7:0] core_rdata,
   input  logic       core_ready,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [2:0] {
      ST_LOAD, ST_START, ST_WAIT, ST_READ, ST_CAPT, ST_SEND
   } state_t;

   // Every output lives in one registered bundle so the next-state logic can
   // compute them all next to the state decision.
   typedef struct packed {
      logic       rx_ready;
      logic [7:0] tx_data;
      logic       tx_valid;
      logic       core_we;
      logic       core_oe;
      logic       core_start;
      logic [1:0] core_reg_sel;
      logic [4:0] core_addr;
      logic [7:0] core_wdata;
      logic       busy;
      logic       timeout_err;
   } out_t;

   state_t      state, state_n;
   logic [6:0]  cnt, cnt_n;
   logic [4:0]  ridx, ridx_n;
   logic [23:0] wcnt, wcnt_n;
   out_t        o, o_n;
   logic        accept;

   assign accept = rx_valid & o.rx_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_LOAD;
         cnt   <= '0;
         ridx  <= '0;
         wcnt  <= '0;
         o     <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         ridx  <= ridx_n;
         wcnt  <= wcnt_n;
         o     <= o_n;
      end
   end

   always_comb begin
      state_n         = state;
      cnt_n           = cnt;
      ridx_n          = ridx;
      wcnt_n          = wcnt;
      o_n             = o;
      o_n.core_we     = 1'b0;
      o_n.core_oe     = 1'b0;
      o_n.core_start  = 1'b0;
      case (state)
         ST_LOAD: begin
            if (accept) begin
               o_n.core_we      = 1'b1;
               o_n.core_wdata   = rx_data;
               o_n.core_reg_sel = cnt[6:5];
               o_n.core_addr    = cnt[4:0];
               o_n.timeout_err  = 1'b0;
               cnt_n            = cnt + 7'd1;
               if (cnt == 7'd95) state_n = ST_START;
            end
         end
         ST_START: begin
            o_n.core_start = 1'b1;
            wcnt_n         = '0;
            state_n        = ST_WAIT;
         end
         ST_WAIT: begin
            // The first WAIT cycle is skipped: core_ready may still show the
            // pre-start idle level while the start pulse is being seen.
            if (wcnt != 24'd0 && core_ready) begin
               state_n = ST_READ;
            end else if (wcnt == TIMEOUT - 24'd1) begin
               o_n.timeout_err = 1'b1;
               cnt_n           = '0;
               state_n         = ST_LOAD;
            end else begin
               wcnt_n = wcnt + 24'd1;
            end
         end
         ST_READ: state_n = ST_CAPT;
         ST_CAPT: begin
            o_n.tx_data  = core_rdata;
            o_n.tx_valid = 1'b1;
            state_n      = ST_SEND;
         end
         ST_SEND: begin
            if (tx_ready) begin
               o_n.tx_valid = 1'b0;
               ridx_n       = ridx + 5'd1;
               if (ridx == 5'd31) begin
                  cnt_n   = '0;
                  state_n = ST_LOAD;
               end else begin
                  state_n = ST_READ;
               end
            end
         end
         default: state_n = ST_LOAD;
      endcase
      o_n.rx_ready = (state_n == ST_LOAD);
      o_n.busy     = (state_n != ST_LOAD);
      if (state_n == ST_READ) begin
         o_n.core_oe      = 1'b1;
         o_n.core_reg_sel = 2'd3;
         o_n.core_addr    = ridx_n;
      end
   end

   assign rx_ready     = o.rx_ready;
   assign tx_data      = o.tx_data;
   assign tx_valid     = o.tx_valid;
   assign core_we      = o.core_we;
   assign core_oe      = o.core_oe;
   assign core_start   = o.core_start;
   assign core_reg_sel = o.core_reg_sel;
   assign core_addr    = o.core_addr;
   assign core_wdata   = o.core_wdata;
   assign busy         = o.busy;
   assign timeout_err  = o.timeout_err;

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Scoreboard bench for rsa_stream_ctrl: random byte streams, a small RSA core
// model, and a monitor that checks every core write, core read and tx byte.
module tb_rsa_stream_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       core_we, core_oe, core_start;
   logic [1:0] core_reg_sel;
   logic [4:0] core_addr;
   logic [7:0] core_wdata;
   logic [7:0] core_rdata = '0;
   logic       core_ready;
   logic       busy, timeout_err;

   always #5 clk = ~clk;

   rsa_stream_ctrl #(.TIMEOUT(24'd16)) dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .core_we(core_we), .core_oe(core_oe), .core_start(core_start),
      .core_reg_sel(core_reg_sel), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(core_rdata),
      .core_ready(core_ready), .busy(busy), .timeout_err(timeout_err)
   );

   typedef struct {
      logic [1:0] sel;
      logic [4:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        wq[$];
   logic [4:0] rdq[$];
   logic [7:0] txq[$];
   logic [7:0] res[32];

   int n_chk = 0, n_fail = 0;
   int k = 0, cyc = 0, last_we_cyc = -10;
   int we_cnt, start_cnt, oe_cnt, tx_cnt, run, max_run, stall_seen;
   int delay = 10, bl = 0, stall_left = 0;
   bit stuck = 0, stall_en = 0, stall_done = 0, tx_rand = 0, sess_a = 0;
   bit hold_prev = 0;
   logic [7:0] prev_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event did not occur, expected it within its bound", name);
   endtask

   // RSA core model: goes not-ready for 'delay' cycles after start, result read
   // back with one cycle of latency after core_oe.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (core_start) bl <= delay;
      else if (bl > 0) bl <= bl - 1;
      if (core_oe) core_rdata <= res[core_addr];
   end
   assign core_ready = (bl == 0) && !stuck;

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (stall_en && tx_valid && tx_cnt == 7 && !stall_done) begin
            stall_left = 5;
            stall_done = 1;
         end
         if (stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
         end else begin
            tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents something.
   always @(negedge clk) begin
      if (!reset) begin
         if (core_we) begin
            we_cnt++;
            run++;
            if (run > max_run) max_run = run;
            last_we_cyc = cyc;
            chk("we_oe_exclusive", core_oe, 0);
            if (wq.size() == 0) fail_now("we_expected");
            else begin
               wr_t e;
               e = wq.pop_front();
               chk("we_sel", core_reg_sel, e.sel);
               chk("we_addr", core_addr, e.addr);
               chk("we_data", core_wdata, e.data);
            end
            if (sess_a && core_wdata == 8'h25) begin
               chk("byte25_sel", core_reg_sel, 1);
               chk("byte25_addr", core_addr, 5);
            end
         end else begin
            run = 0;
         end
         if (core_start) begin
            start_cnt++;
            chk("start_gap", cyc - last_we_cyc, 1);
         end
         if (core_oe) begin
            oe_cnt++;
            chk("oe_sel", core_reg_sel, 3);
            if (rdq.size() == 0) fail_now("oe_expected");
            else chk("oe_addr", core_addr, rdq.pop_front());
         end
         if (tx_valid) begin
            if (hold_prev) chk("tx_stable", tx_data, prev_data);
            if (tx_ready) begin
               if (txq.size() == 0) fail_now("tx_expected");
               else chk("tx_data", tx_data, txq.pop_front());
               tx_cnt++;
               hold_prev = 0;
            end else begin
               hold_prev = 1;
               prev_data = tx_data;
               if (tx_cnt == 7) stall_seen++;
            end
         end
      end
   end

   task automatic start_session(input bit reads);
      k = 0; we_cnt = 0; start_cnt = 0; oe_cnt = 0; tx_cnt = 0;
      max_run = 0; run = 0; stall_seen = 0; stall_done = 0; hold_prev = 0;
      wq.delete(); rdq.delete(); txq.delete();
      if (reads)
         for (int i = 0; i < 32; i++) begin
            res[i] = 8'($urandom);
            rdq.push_back(5'(i));
            txq.push_back(res[i]);
         end
   endtask

   // Reference: the k-th accepted byte of a load goes to register k/32, byte k%32.
   task automatic send_byte(input logic [7:0] b);
      bit done = 0;
      wr_t w;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (rx_ready) begin
            w.sel = 2'(k / 32); w.addr = 5'(k % 32); w.data = b;
            wq.push_back(w);
            k++;
            done = 1;
         end
      end
      if (!done) fail_now("rx_accept");
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic load(input int mode);
      for (int i = 0; i < 96; i++) begin
         send_byte(mode == 0 ? 8'(i) : 8'($urandom));
         if (mode == 1) begin
            repeat (2) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_session();
      bit done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (tx_cnt >= 16) rx_valid = 1'b0;
         if (tx_cnt == 32 && rx_ready) done = 1;
      end
      if (!done) fail_now("session_end");
      chk("we_count", we_cnt, 96);
      chk("start_count", start_cnt, 1);
      chk("oe_count", oe_cnt, 32);
      chk("queues_drained", wq.size() + rdq.size() + txq.size(), 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit found;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {rx_ready, tx_valid, tx_data, core_we, core_oe, core_start,
          core_reg_sel, core_addr, core_wdata, busy, timeout_err}, 0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      chk("rx_ready_after_reset", rx_ready, 1);

      // back-to-back 0x00..0x5F, slow core, tx stall on byte 7, rx noise while busy
      start_session(1);
      sess_a = 1; stall_en = 1; delay = 10;
      load(0);
      chk("rx_ready_dropped", rx_ready, 0);
      rx_data = 8'hEE; rx_valid = 1'b1;
      wait_session();
      chk("b2b_run", max_run, 96);
      chk("stall_cycles", stall_seen, 5);
      sess_a = 0; stall_en = 0;

      // throttled load, random core latency and tx backpressure
      @(posedge clk); #1;
      start_session(1);
      tx_rand = 1; delay = $urandom_range(1, 12);
      load(1);
      wait_session();
      chk("throttled_run", max_run, 1);

      // core never ready: timeout
      @(posedge clk); #1;
      start_session(0);
      stuck = 1;
      load(2);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (core_start) found = 1;
      end
      if (!found) fail_now("timeout_start");
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (i == 15) chk("timeout_err_early", timeout_err, 0);
         if (i == 16) begin
            chk("timeout_err_set", timeout_err, 1);
            chk("timeout_rx_ready", rx_ready, 1);
         end
      end
      start_session(0);
      stuck = 0;
      @(posedge clk); #1;
      send_byte(8'($urandom));
      chk("timeout_err_cleared", timeout_err, 0);
      for (int i = 1; i < 50; i++) send_byte(8'($urandom));

      // reset during byte 50 of a load
      @(negedge clk); #2;
      rx_data = 8'($urandom); rx_valid = 1'b1; reset = 1'b1;
      #1;
      chk("midreset_outputs", {rx_ready, tx_valid, tx_data, core_we, core_oe, core_start,
          core_reg_sel, core_addr, core_wdata, busy, timeout_err}, 0);
      start_session(1);
      delay = $urandom_range(1, 12);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; rx_valid = 1'b0;
      @(posedge clk); #1;
      chk("rx_ready_after_midreset", rx_ready, 1);
      load(2);
      wait_session();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
